// File: rtl/poly_lfsr_checker.sv
// Purpose : self-synchronising checker for a polyphase Fibonacci LFSR stream (POLY states per beat).
// Latency : every output is registered and reflects a beat exactly one cycle after it is presented.
// Backpr. : none; a beat is consumed on every cycle in_valid is high.
module poly_lfsr_checker #(
    parameter int              WIDTH      = 16,
    parameter int              POLY       = 8,
    parameter logic [WIDTH-1:0] TAPS      = 16'hD008,
    parameter int              LOCK_CNT   = 4,
    parameter int              UNLOCK_CNT = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [POLY-1:0][WIDTH-1:0]  q,
    input  logic                        clear,
    output logic                        locked,
    output logic                        err_pulse,
    output logic [31:0]                 err_count,
    output logic [31:0]                 beat_count
);

    localparam int MW = $clog2(POLY + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state;
    logic [GW-1:0]    good_run;
    logic [BW-1:0]    bad_run;
    logic [WIDTH-1:0] prev;
    logic             prev_valid;

    logic [POLY-1:0]  lane_fail;
    logic [MW-1:0]    mism;
    logic             clean;
    logic [32:0]      err_sum;
    logic [31:0]      err_next;
    logic [31:0]      beat_next;

    // One LFSR step: shift left, new LSB is the parity of the tapped bits.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        step = {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    // Per-lane successor check; an all-zero lane is the lockup state and always fails.
    always_comb begin
        lane_fail    = '0;
        lane_fail[0] = (q[0] == '0) || (prev_valid && (q[0] != step(prev)));
        for (int k = 1; k < POLY; k++) begin
            lane_fail[k] = (q[k] == '0) || (q[k] != step(q[k-1]));
        end
    end

    // Number of failing lanes in the current beat.
    always_comb begin
        mism = '0;
        for (int k = 0; k < POLY; k++) begin
            mism = mism + MW'(lane_fail[k]);
        end
    end

    assign clean     = (mism == '0);
    assign err_sum   = {1'b0, err_count} + {{(33-MW){1'b0}}, mism};
    assign err_next  = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    assign beat_next = (beat_count == 32'hFFFF_FFFF) ? beat_count : beat_count + 32'd1;

    // Remember the newest lane of each valid beat to chain lane 0 of the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (in_valid) begin
            prev       <= q[POLY-1];
            prev_valid <= 1'b1;
        end
    end

    // Lock FSM with registered locked/err_pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            good_run  <= '0;
            bad_run   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        if (clean) begin
                            if (good_run == GW'(LOCK_CNT - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                good_run <= '0;
                                bad_run  <= '0;
                            end else begin
                                good_run <= good_run + 1'b1;
                            end
                        end else begin
                            good_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!clean) begin
                            err_pulse <= 1'b1;
                            if (bad_run == BW'(UNLOCK_CNT - 1)) begin
                                state    <= SEARCH;
                                locked   <= 1'b0;
                                bad_run  <= '0;
                                good_run <= '0;
                            end else begin
                                bad_run <= bad_run + 1'b1;
                            end
                        end else begin
                            bad_run <= '0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating statistics; clear takes priority over a coincident beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count  <= '0;
            beat_count <= '0;
        end else if (clear) begin
            err_count  <= '0;
            beat_count <= '0;
        end else if (in_valid) begin
            beat_count <= beat_next;
            if (state == LOCKED && !clean) begin
                err_count <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_poly_lfsr_checker.sv
// Directed bench for poly_lfsr_checker: reference model plus hand-computed checkpoints.
module tb_poly_lfsr_checker;

    localparam int WIDTH      = 16;
    localparam int POLY       = 8;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 3;
    localparam logic [15:0] TAPS_TB = 16'hD008;

    typedef logic [POLY-1:0][WIDTH-1:0] beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    beat_t       q = '0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_count;
    logic [31:0] beat_count;

    int total = 0;
    int bad   = 0;

    poly_lfsr_checker #(
        .WIDTH(WIDTH), .POLY(POLY), .TAPS(16'hD008),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .q(q), .clear(clear),
        .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    // Reference LFSR step computed bit by bit from the tap mask.
    function automatic logic [WIDTH-1:0] ref_step(input logic [WIDTH-1:0] s);
        int fb;
        fb = 0;
        for (int b = 0; b < WIDTH; b++) begin
            if (TAPS_TB[b] && s[b]) fb = fb ^ 1;
        end
        return WIDTH'((32'(s) << 1) | fb);
    endfunction

    // Count lanes that break the chain, walking the beat from the remembered state.
    function automatic int count_mism(input beat_t d, input logic [WIDTH-1:0] p, input bit pv);
        int n;
        logic [WIDTH-1:0] last;
        bit have_last;
        n = 0;
        last = p;
        have_last = pv;
        for (int k = 0; k < POLY; k++) begin
            if (d[k] == 0) n++;
            else if (have_last && d[k] != ref_step(last)) n++;
            last = d[k];
            have_last = 1;
        end
        return n;
    endfunction

    // Behavioural model state.
    bit               m_locked = 0;
    bit               m_pulse = 0;
    bit               m_prev_valid = 0;
    logic [WIDTH-1:0] m_prev = '0;
    int               m_good = 0;
    int               m_bad = 0;
    longint           m_err = 0;
    longint           m_beats = 0;
    int               tb_mism;

    always_comb tb_mism = count_mism(q, m_prev, m_prev_valid);

    function automatic longint sat32(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_locked <= 0; m_pulse <= 0; m_prev_valid <= 0; m_prev <= '0;
            m_good <= 0; m_bad <= 0; m_err <= 0; m_beats <= 0;
        end else begin
            m_pulse <= 0;
            if (clear) begin
                m_err   <= 0;
                m_beats <= 0;
            end
            if (in_valid) begin
                m_prev       <= q[POLY-1];
                m_prev_valid <= 1;
                if (!clear) m_beats <= sat32(m_beats + 1);
                if (!m_locked) begin
                    if (tb_mism == 0) begin
                        if (m_good + 1 >= LOCK_CNT) begin m_locked <= 1; m_good <= 0; m_bad <= 0; end
                        else m_good <= m_good + 1;
                    end else begin
                        m_good <= 0;
                    end
                end else if (tb_mism != 0) begin
                    m_pulse <= 1;
                    if (!clear) m_err <= sat32(m_err + tb_mism);
                    if (m_bad + 1 >= UNLOCK_CNT) begin m_locked <= 0; m_bad <= 0; m_good <= 0; end
                    else m_bad <= m_bad + 1;
                end else begin
                    m_bad <= 0;
                end
            end
        end
    end

    // Every cycle, DUT outputs must match the model.
    always @(negedge clk) begin
        total++;
        if (locked !== m_locked || err_pulse !== m_pulse ||
            err_count !== 32'(m_err) || beat_count !== 32'(m_beats)) begin
            bad++;
            $display("FAIL model_cmp t=%0t locked=%b/%b pulse=%b/%b err=%0d/%0d beats=%0d/%0d",
                     $time, locked, m_locked, err_pulse, m_pulse,
                     err_count, 32'(m_err), beat_count, 32'(m_beats));
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input beat_t d, input logic c);
        @(negedge clk);
        in_valid = v;
        q        = d;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] gen_s;

    task automatic make_beat(output beat_t b);
        b[0] = gen_s;
        for (int k = 1; k < POLY; k++) b[k] = ref_step(b[k-1]);
        gen_s = ref_step(b[POLY-1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        beat_t b;
        beat_t z;
        z = '0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_err", err_count, 0);
        chk("rst_beats", beat_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Acquire lock from seed 0x0001
        gen_s = 16'h0001;
        for (int i = 1; i <= 4; i++) begin
            make_beat(b);
            if (i == 1) chk("gen_lane7", b[7], 16'h0088);
            drive(1'b1, b, 1'b0);
            chk("lock_acq", locked, (i == 4) ? 1 : 0);
            chk("lock_beats", beat_count, i);
        end
        chk("lock_err", err_count, 0);

        // Bit flip inside a beat: two lanes fail
        make_beat(b);
        b[3][0] = ~b[3][0];
        drive(1'b1, b, 1'b0);
        chk("flip3_err", err_count, 2);
        chk("flip3_pulse", err_pulse, 1);
        chk("flip3_locked", locked, 1);
        make_beat(b);
        drive(1'b1, b, 1'b0);
        chk("flip3_pulse_off", err_pulse, 0);
        chk("flip3_err_hold", err_count, 2);

        // Newest lane corrupted: error carries into next beat's lane 0
        make_beat(b);
        drive(1'b1, b, 1'b1);
        chk("clr_err", err_count, 0);
        chk("clr_beats", beat_count, 0);
        make_beat(b);
        b[7] = b[7] ^ 16'h0001;
        drive(1'b1, b, 1'b0);
        chk("flip7_err_a", err_count, 1);
        chk("flip7_pulse_a", err_pulse, 1);
        make_beat(b);
        drive(1'b1, b, 1'b0);
        chk("flip7_err_b", err_count, 2);
        chk("flip7_pulse_b", err_pulse, 1);
        make_beat(b);
        drive(1'b1, b, 1'b0);
        chk("flip7_pulse_off", err_pulse, 0);
        chk("flip7_locked", locked, 1);

        // All-zero beats force unlock; relock needs five beats
        make_beat(b);
        drive(1'b1, b, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, z, 1'b0);
            chk("zero_err", err_count, 8 * i);
            chk("zero_locked", locked, (i == 3) ? 0 : 1);
        end
        for (int i = 1; i <= 5; i++) begin
            make_beat(b);
            drive(1'b1, b, 1'b0);
            chk("relock", locked, (i == 5) ? 1 : 0);
        end
        chk("relock_err", err_count, 24);

        // Clear coincident with an errored beat
        make_beat(b);
        b[3][0] = ~b[3][0];
        drive(1'b1, b, 1'b1);
        chk("clr_bad_err", err_count, 0);
        chk("clr_bad_beats", beat_count, 0);
        chk("clr_bad_pulse", err_pulse, 1);

        // Build err_count = 5 while locked
        make_beat(b);
        b[1][0] = ~b[1][0];
        b[3][0] = ~b[3][0];
        drive(1'b1, b, 1'b0);
        chk("e5_four", err_count, 4);
        make_beat(b);
        drive(1'b1, b, 1'b0);
        make_beat(b);
        b[7] = b[7] ^ 16'h0001;
        drive(1'b1, b, 1'b0);
        chk("e5_err", err_count, 5);
        chk("e5_locked", locked, 1);
        drive(1'b0, z, 1'b0);
        chk("idle_err", err_count, 5);
        chk("idle_pulse", err_pulse, 0);

        // Asynchronous reset mid-operation
        #2 reset = 1'b1;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_err", err_count, 0);
        chk("arst_beats", beat_count, 0);
        chk("arst_pulse", err_pulse, 0);
        @(negedge clk);
        reset = 1'b0;

        // Alternate valid/idle: lock timing counted in valid beats
        for (int i = 1; i <= 4; i++) begin
            make_beat(b);
            drive(1'b1, b, 1'b0);
            chk("tog_lock", locked, (i == 4) ? 1 : 0);
            drive(1'b0, z, 1'b0);
            chk("tog_lock_idle", locked, (i == 4) ? 1 : 0);
            chk("tog_pulse", err_pulse, 0);
        end
        chk("tog_beats", beat_count, 4);
        chk("tog_err", err_count, 0);

        drive(1'b0, z, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
